jtag_tap_sampled: RTL and testbench

Synthesizable JTAG TAP responder: the target end of the JTAG link that the simulation JTAG driver initiates (TCK/TMS/TDI/TRST in, TDO out). It oversamples the JTAG pins with the system clock and runs the IEEE 1149.1 16-state TAP FSM. It implements IR, IDCODE and BYPASS internally, and exposes DTMCS and DMI data registers to the debug-module side as capture values plus update strobes. It sits between the SoC JTAG pins and the DMI front-end of the debug module.

---
 rtl/jtag_tap_pkg.sv | 63 ++++++
 rtl/jtag_pin_sync.sv | 40 ++++
 rtl/jtag_tap_sampled.sv | 175 +++++++++++++++++
 tb/tb_jtag_tap_sampled.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding, DR selection, default
// opcodes and the TAP next-state function.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    Exit2Dr        = 4'h0,
    Exit1Dr        = 4'h1,
    ShiftDr        = 4'h2,
    PauseDr        = 4'h3,
    SelectIrScan   = 4'h4,
    UpdateDr       = 4'h5,
    CaptureDr      = 4'h6,
    SelectDrScan   = 4'h7,
    Exit2Ir        = 4'h8,
    Exit1Ir        = 4'h9,
    ShiftIr        = 4'hA,
    PauseIr        = 4'hB,
    RunTestIdle    = 4'hC,
    UpdateIr       = 4'hD,
    CaptureIr      = 4'hE,
    TestLogicReset = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    SelBypass,
    SelIdcode,
    SelDtmcs,
    SelDmi
  } dr_sel_e;

  localparam logic [4:0] IdcodeOp = 5'h01;
  localparam logic [4:0] DtmcsOp  = 5'h10;
  localparam logic [4:0] DmiOp    = 5'h11;

  function automatic int dmiWidth(input int abits);
    return abits + 34;
  endfunction

  function automatic tap_state_e tapNext(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TestLogicReset: n = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    n = tms ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   n = tms ? SelectIrScan   : CaptureDr;
      CaptureDr:      n = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        n = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        n = tms ? UpdateDr       : PauseDr;
      PauseDr:        n = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        n = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       n = tms ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   n = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      n = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        n = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        n = tms ? UpdateIr       : PauseIr;
      PauseIr:        n = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        n = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       n = tms ? SelectDrScan   : RunTestIdle;
      default:        n = TestLogicReset;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Brings the JTAG pins into the system clock domain and turns TCK into
// single-clock rise/fall events.
module jtag_pin_sync (
  input  logic clock,
  input  logic reset_i,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  input  logic trst_ni,
  output logic tck_rise_o,
  output logic tck_fall_o,
  output logic tms_s_o,
  output logic tdi_s_o,
  output logic trst_ns_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic       tckPrev_q;

  // All four pins share one synchronizer depth so TMS/TDI line up with TCK.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      meta_q    <= '0;
      sync_q    <= '0;
      tckPrev_q <= 1'b0;
    end else begin
      meta_q    <= {trst_ni, tdi_i, tms_i, tck_i};
      sync_q    <= meta_q;
      tckPrev_q <= sync_q[0];
    end
  end

  assign tck_rise_o = sync_q[0] & ~tckPrev_q;
  assign tck_fall_o = ~sync_q[0] & tckPrev_q;
  assign tms_s_o    = sync_q[1];
  assign tdi_s_o    = sync_q[2];
  assign trst_ns_o  = sync_q[3];

endmodule

// File: rtl/jtag_tap_sampled.sv
// Oversampled JTAG TAP: IR, IDCODE and BYPASS live here; DTMCS and DMI are
// handed to the debug module as capture values plus update strobes.
module jtag_tap_sampled
  import jtag_tap_pkg::*;
#(
  parameter int          IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h04F5484D,
  parameter int          AbitsDmi    = 7,
  parameter logic [IrLength-1:0] IdcodeInstr = IdcodeOp,
  parameter logic [IrLength-1:0] DtmcsInstr  = DtmcsOp,
  parameter logic [IrLength-1:0] DmiInstr    = DmiOp
) (
  input  logic                  clock,
  input  logic                  reset_i,
  input  logic                  jtag_tck_i,
  input  logic                  jtag_tms_i,
  input  logic                  jtag_tdi_i,
  input  logic                  jtag_trst_ni,
  output logic                  jtag_tdo_o,
  output logic                  jtag_tdo_oe_o,
  input  logic [31:0]           dtmcs_capture_i,
  output logic [31:0]           dtmcs_wdata_o,
  output logic                  dtmcs_update_o,
  input  logic [AbitsDmi+33:0]  dmi_capture_i,
  output logic [AbitsDmi+33:0]  dmi_wdata_o,
  output logic                  dmi_update_o,
  output logic                  dmi_capture_o,
  output logic [3:0]            tap_state_o
);

  localparam int DmiW = dmiWidth(AbitsDmi);
  localparam logic [IrLength-1:0] IrCapture = {{(IrLength-2){1'b0}}, 2'b01};

  logic tckRise, tckFall, tmsS, tdiS, trstNs;

  tap_state_e          tapState_q, tapState_d;
  logic [IrLength-1:0] ir_q, ir_d, irShift_q, irShift_d;
  logic [31:0]         dr32_q, dr32_d;
  logic [DmiW-1:0]     dmiShift_q, dmiShift_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d, tdoOe_q, tdoOe_d;
  logic                dmiUpdate_q, dmiUpdate_d;
  logic                dtmcsUpdate_q, dtmcsUpdate_d;
  logic                dmiCapture_q, dmiCapture_d;
  dr_sel_e             drSel;

  jtag_pin_sync u_pin_sync (
    .clock      (clock),
    .reset_i    (reset_i),
    .tck_i      (jtag_tck_i),
    .tms_i      (jtag_tms_i),
    .tdi_i      (jtag_tdi_i),
    .trst_ni    (jtag_trst_ni),
    .tck_rise_o (tckRise),
    .tck_fall_o (tckFall),
    .tms_s_o    (tmsS),
    .tdi_s_o    (tdiS),
    .trst_ns_o  (trstNs)
  );

  // Unknown opcodes, all-ones included, fall through to BYPASS.
  always_comb begin
    drSel = SelBypass;
    if (ir_q == IdcodeInstr)     drSel = SelIdcode;
    else if (ir_q == DtmcsInstr) drSel = SelDtmcs;
    else if (ir_q == DmiInstr)   drSel = SelDmi;
  end

  always_comb begin
    tapState_d    = tapState_q;
    ir_d          = ir_q;
    irShift_d     = irShift_q;
    dr32_d        = dr32_q;
    dmiShift_d    = dmiShift_q;
    bypass_d      = bypass_q;
    tdo_d         = tdo_q;
    tdoOe_d       = tdoOe_q;
    dmiUpdate_d   = 1'b0;
    dtmcsUpdate_d = 1'b0;
    dmiCapture_d  = 1'b0;

    if (!trstNs) begin
      tapState_d = TestLogicReset;
      ir_d       = IdcodeInstr;
      irShift_d  = '0;
      dr32_d     = '0;
      dmiShift_d = '0;
      bypass_d   = 1'b0;
      tdo_d      = 1'b0;
      tdoOe_d    = 1'b0;
    end else if (tckRise) begin
      case (tapState_q)
        TestLogicReset: ir_d = IdcodeInstr;
        CaptureIr:      irShift_d = IrCapture;
        ShiftIr:        irShift_d = {tdiS, irShift_q[IrLength-1:1]};
        UpdateIr:       ir_d = irShift_q;
        CaptureDr: begin
          case (drSel)
            SelIdcode: dr32_d = IdcodeValue;
            SelDtmcs:  dr32_d = dtmcs_capture_i;
            SelDmi: begin
              dmiShift_d   = dmi_capture_i;
              dmiCapture_d = 1'b1;
            end
            default:   bypass_d = 1'b0;
          endcase
        end
        ShiftDr: begin
          case (drSel)
            SelIdcode, SelDtmcs: dr32_d = {tdiS, dr32_q[31:1]};
            SelDmi:              dmiShift_d = {tdiS, dmiShift_q[DmiW-1:1]};
            default:             bypass_d = tdiS;
          endcase
        end
        default: ;
      endcase
      tapState_d = tapNext(tapState_q, tmsS);
      // Strobe registers fire together with the state register entering Update-DR.
      if (tapState_d == UpdateDr) begin
        dtmcsUpdate_d = (drSel == SelDtmcs);
        dmiUpdate_d   = (drSel == SelDmi);
      end
    end else if (tckFall) begin
      tdoOe_d = (tapState_q == ShiftIr) || (tapState_q == ShiftDr);
      tdo_d   = 1'b0;
      if (tapState_q == ShiftIr) begin
        tdo_d = irShift_q[0];
      end else if (tapState_q == ShiftDr) begin
        case (drSel)
          SelIdcode, SelDtmcs: tdo_d = dr32_q[0];
          SelDmi:              tdo_d = dmiShift_q[0];
          default:             tdo_d = bypass_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      tapState_q    <= TestLogicReset;
      ir_q          <= IdcodeInstr;
      irShift_q     <= '0;
      dr32_q        <= '0;
      dmiShift_q    <= '0;
      bypass_q      <= 1'b0;
      tdo_q         <= 1'b0;
      tdoOe_q       <= 1'b0;
      dmiUpdate_q   <= 1'b0;
      dtmcsUpdate_q <= 1'b0;
      dmiCapture_q  <= 1'b0;
    end else begin
      tapState_q    <= tapState_d;
      ir_q          <= ir_d;
      irShift_q     <= irShift_d;
      dr32_q        <= dr32_d;
      dmiShift_q    <= dmiShift_d;
      bypass_q      <= bypass_d;
      tdo_q         <= tdo_d;
      tdoOe_q       <= tdoOe_d;
      dmiUpdate_q   <= dmiUpdate_d;
      dtmcsUpdate_q <= dtmcsUpdate_d;
      dmiCapture_q  <= dmiCapture_d;
    end
  end

  assign jtag_tdo_o     = tdo_q;
  assign jtag_tdo_oe_o  = tdoOe_q;
  assign dtmcs_wdata_o  = dr32_q;
  assign dtmcs_update_o = dtmcsUpdate_q;
  assign dmi_wdata_o    = dmiShift_q;
  assign dmi_update_o   = dmiUpdate_q;
  assign dmi_capture_o  = dmiCapture_q;
  assign tap_state_o    = tapState_q;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Scoreboard bench for jtag_tap_sampled: the JTAG driver queues expected TDO
// bits and update payloads, a clock-domain monitor pops them as the DUT emits.
module tb_jtag_tap_sampled;
  import jtag_tap_pkg::*;

  localparam logic [31:0] IdcodeValue = 32'h04F5484D;

  logic        clock;
  logic        reset;
  logic        jtagTck, jtagTms, jtagTdi, jtagTrstN;
  logic        jtagTdo, jtagTdoOe;
  logic [31:0] dtmcsCapture, dtmcsWdata;
  logic        dtmcsUpdate;
  logic [40:0] dmiCapture, dmiWdata;
  logic        dmiUpdate, dmiCaptureStrobe;
  logic [3:0]  tapState;

  int totalCount  = 0;
  int badCount    = 0;
  int dmiCapCount = 0;

  logic        tdoQ[$];
  logic [63:0] dmiUpdQ[$];
  logic [63:0] dtmcsUpdQ[$];
  logic        tckPrev;

  jtag_tap_sampled dut (
    .clock           (clock),
    .reset_i         (reset),
    .jtag_tck_i      (jtagTck),
    .jtag_tms_i      (jtagTms),
    .jtag_tdi_i      (jtagTdi),
    .jtag_trst_ni    (jtagTrstN),
    .jtag_tdo_o      (jtagTdo),
    .jtag_tdo_oe_o   (jtagTdoOe),
    .dtmcs_capture_i (dtmcsCapture),
    .dtmcs_wdata_o   (dtmcsWdata),
    .dtmcs_update_o  (dtmcsUpdate),
    .dmi_capture_i   (dmiCapture),
    .dmi_wdata_o     (dmiWdata),
    .dmi_update_o    (dmiUpdate),
    .dmi_capture_o   (dmiCaptureStrobe),
    .tap_state_o     (tapState)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One TCK period of 16 system clocks; TMS/TDI change while TCK is low.
  task automatic applyStimulus(input logic tms, input logic tdi);
    jtagTms = tms;
    jtagTdi = tdi;
    #40 jtagTck = 1'b1;
    #80 jtagTck = 1'b0;
    #40;
  endtask

  task automatic shiftBits(input int n, input logic [63:0] tdiV, input logic [63:0] expV, input bit exitLast);
    for (int i = 0; i < n; i++) begin
      tdoQ.push_back(expV[i]);
      applyStimulus(exitLast && (i == n - 1), tdiV[i]);
    end
  endtask

  task automatic scanDr(input int n, input logic [63:0] tdiV, input logic [63:0] expV);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    shiftBits(n, tdiV, expV, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic scanIr(input logic [4:0] val);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    shiftBits(5, 64'(val), 64'h01, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  // Monitor: TDO is checked when TCK rises with the output enabled, update
  // payloads on every clock their strobe is high.
  initial begin
    tckPrev = 1'b0;
    forever begin
      @(negedge clock);
      if (jtagTck && !tckPrev && jtagTdoOe) begin
        if (tdoQ.size() == 0) checkOutput("tdo_oe_unexpected", 64'(jtagTdoOe), 64'h0);
        else checkOutput("tdo_bit", 64'(jtagTdo), 64'(tdoQ.pop_front()));
      end
      if (dmiUpdate) begin
        if (dmiUpdQ.size() == 0) checkOutput("dmi_update_unexpected", 64'(dmiUpdate), 64'h0);
        else checkOutput("dmi_wdata", 64'(dmiWdata), dmiUpdQ.pop_front());
      end
      if (dtmcsUpdate) begin
        if (dtmcsUpdQ.size() == 0) checkOutput("dtmcs_update_unexpected", 64'(dtmcsUpdate), 64'h0);
        else checkOutput("dtmcs_wdata", 64'(dtmcsWdata), dtmcsUpdQ.pop_front());
      end
      if (dmiCaptureStrobe) dmiCapCount++;
      tckPrev = jtagTck;
    end
  end

  initial begin
    reset        = 1'b1;
    jtagTck      = 1'b0;
    jtagTms      = 1'b1;
    jtagTdi      = 1'b0;
    jtagTrstN    = 1'b1;
    dtmcsCapture = 32'h0000_5A7F;
    dmiCapture   = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_state", 64'(tapState), 64'(TestLogicReset));
    checkOutput("reset_tdo_oe", 64'(jtagTdoOe), 64'h0);
    checkOutput("reset_dmi_wdata", 64'(dmiWdata), 64'h0);
    @(negedge clock) reset = 1'b0;
    repeat (4) @(negedge clock);

    $display("[TB] IDCODE read after TMS reset");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("state_after_tms_reset", 64'(tapState), 64'(TestLogicReset));
    applyStimulus(1'b0, 1'b0);
    checkOutput("state_rti", 64'(tapState), 64'(RunTestIdle));
    scanDr(32, 64'h0, 64'(IdcodeValue));
    checkOutput("state_rti_after_dr", 64'(tapState), 64'(RunTestIdle));

    $display("[TB] BYPASS via all-ones opcode");
    scanIr(5'h1F);
    scanDr(4, 64'b1101, 64'b1010);

    $display("[TB] DMI capture/update");
    scanIr(5'h11);
    dmiCapture = 41'h1_2345_6789;
    dmiUpdQ.push_back(64'h0A_DEAD_BEEF);
    scanDr(41, 64'h0A_DEAD_BEEF, 64'h1_2345_6789);
    checkOutput("dmi_wdata_hold", 64'(dmiWdata), 64'h0A_DEAD_BEEF);
    checkOutput("dmi_capture_pulses", 64'(dmiCapCount), 64'd1);

    $display("[TB] DTMCS write");
    scanIr(5'h10);
    dtmcsUpdQ.push_back(64'h0001_0000);
    scanDr(32, 64'h0001_0000, 64'h0000_5A7F);
    checkOutput("dtmcs_wdata_hold", 64'(dtmcsWdata), 64'h0001_0000);

    $display("[TB] TRST mid Shift-DR");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    shiftBits(3, 64'h0, 64'h7, 1'b0);
    checkOutput("tdo_before_trst", 64'(jtagTdo), 64'h1);
    @(negedge clock) jtagTrstN = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("trst_state", 64'(tapState), 64'(TestLogicReset));
    checkOutput("trst_tdo_oe", 64'(jtagTdoOe), 64'h0);
    checkOutput("trst_tdo", 64'(jtagTdo), 64'h0);
    repeat (4) @(negedge clock);
    jtagTrstN = 1'b1;
    repeat (4) @(negedge clock);
    applyStimulus(1'b0, 1'b0);
    checkOutput("state_rti_after_trst", 64'(tapState), 64'(RunTestIdle));
    scanDr(32, 64'h0, 64'(IdcodeValue));

    $display("[TB] async reset mid Shift-IR");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    shiftBits(5, 64'h1F, 64'h01, 1'b0);
    checkOutput("state_shift_ir", 64'(tapState), 64'(ShiftIr));
    checkOutput("tdo_before_reset", 64'(jtagTdo), 64'h1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checkOutput("async_reset_state", 64'(tapState), 64'(TestLogicReset));
    checkOutput("async_reset_tdo_oe", 64'(jtagTdoOe), 64'h0);
    checkOutput("async_reset_tdo", 64'(jtagTdo), 64'h0);
    @(negedge clock) reset = 1'b0;
    repeat (4) @(negedge clock);
    applyStimulus(1'b0, 1'b0);
    checkOutput("state_rti_after_reset", 64'(tapState), 64'(RunTestIdle));
    scanDr(32, 64'h0, 64'(IdcodeValue));

    repeat (20) @(negedge clock);
    checkOutput("tdo_queue_drained", 64'(tdoQ.size()), 64'h0);
    checkOutput("dmi_queue_drained", 64'(dmiUpdQ.size()), 64'h0);
    checkOutput("dtmcs_queue_drained", 64'(dtmcsUpdQ.size()), 64'h0);
    checkOutput("dmi_capture_total", 64'(dmiCapCount), 64'd1);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
